fp_div_scheduler: RTL and testbench
===================================

// Module: fp_div_scheduler
// PURPOSE
//   Sequencer and arbiter that shares one FloatingDivision datapath between two requesters.
//   - Arbitrates round-robin and registers operands, holding them stable for the divider's fixed LATENCY.
//   - Captures result/flags and returns them over a valid/ready response port tagged with the requester id.
//   - Resolves IEEE special operands (zero, inf, NaN) itself, bypassing the datapath.
// PARAMETERS
//   XLEN     32  operand/result width; IEEE-754 single only (sign[31], exp[30:23], mant[22:0])
//   LATENCY  8   cycles from div_a/div_b stable to div_result valid; legal range 1..255
// PORTS
//   clk            in   1     rising-edge clock
//   rst            in   1     synchronous reset, active-high
//   req0_valid     in   1     requester 0 has an operation
//   req0_ready     out  1     requester 0 accepted this cycle when valid & ready
//   req0_a         in   XLEN  dividend, requester 0
//   req0_b         in   XLEN  divisor, requester 0
//   req1_valid     in   1     requester 1 has an operation
//   req1_ready     out  1     requester 1 accepted this cycle when valid & ready
//   req1_a         in   XLEN  dividend, requester 1
//   req1_b         in   XLEN  divisor, requester 1
//   div_a          out  XLEN  registered dividend to datapath
//   div_b          out  XLEN  registered divisor to datapath
//   div_result     in   XLEN  datapath quotient
//   div_overflow   in   1     datapath overflow flag
//   div_underflow  in   1     datapath underflow flag
//   div_exception  in   1     datapath exception flag
//   rsp_valid      out  1     response available
//   rsp_ready      in   1     consumer takes response when valid & ready
//   rsp_id         out  1     requester that issued the operation
//   rsp_result     out  XLEN  quotient
//   rsp_overflow   out  1     overflow flag
//   rsp_underflow  out  1     underflow flag
//   rsp_exception  out  1     exception flag
//   busy           out  1     1 whenever state != IDLE
// BEHAVIOUR
//   Reset
//   - All outputs are 0; state = IDLE; round-robin pointer = 0.
//   - Reset mid-operation drops the in-flight op; no response is produced for it.
//   Arbitration and acceptance
//   - reqN_ready is combinational and can be 1 only in IDLE.
//   - Grant goes to the single valid requester. If both are valid, grant goes to the pointer's requester.
//   - On acceptance the pointer flips to the other requester.
//   Operand registers
//   - On acceptance (cycle T), div_a/div_b load the operands and rsp_id loads the winner's id.
//   - div_a/div_b hold until the next acceptance.
//   State machine
//   - IDLE -> BUSY on accept of a normal op; counter loads LATENCY-1.
//   - IDLE -> DONE on accept of a special op; result is decoded from the operands.
//   - BUSY: counter decrements each cycle. At count 0, capture div_result and the three flags, then -> DONE.
//     BUSY therefore spans cycles T+1..T+LATENCY, and rsp_valid=1 from T+LATENCY+1.
//   - DONE: rsp_valid=1 and all rsp_* stay stable until rsp_ready=1, then -> IDLE.
//   - No new accept occurs in the cycle DONE exits; the earliest next accept is the following cycle.
//   Special operands (bypass; rsp_valid=1 at T+1; overflow=underflow=0)
//   - Decoding: exp==0 is treated as zero (flush-to-zero). NaN = exp FF with mant!=0. Inf = exp FF with mant==0.
//   - A or B NaN, 0/0, or inf/inf: result 32'h7FC00000, exception=1.
//   - finite/0: signed inf {sA^sB, 8'hFF, 23'h0}, exception=1.
//   - inf/finite: signed inf, exception=0.
//   - 0/finite or finite/inf: signed zero {sA^sB, 31'h0}, exception=0.
// TESTING
//   - Single op, requester 0, with FloatingDivision attached: A=40C00000 (6.0), B=40000000 (2.0)
//     -> rsp_valid rises exactly LATENCY+1 cycles after accept; rsp_result=40400000; rsp_id=0; flags 0.
//   - Both requesters valid from reset:
//     -> grants alternate 0,1,0,1 over four ops; each reqN_ready pulses exactly once per op.
//   - Backpressure: hold rsp_ready=0 for 20 cycles in DONE
//     -> rsp_* stay stable, busy=1, both reqN_ready=0; release -> IDLE next cycle.
//   - Bypass cases, each -> rsp_valid at T+1, div_result ignored:
//       3F800000/00000000 -> 7F800000, exc=1
//       80000000/3F800000 -> 80000000, exc=0
//       7FC00001/3F800000 -> 7FC00000, exc=1
//   - Reset asserted in BUSY at count 3 -> next cycle all outputs 0; no rsp_valid afterwards;
//     a new request is accepted in the first cycle after rst deasserts.
//   - LATENCY=1 build: 6.0/2.0 -> rsp_valid at T+2; the BUSY count 0 boundary is correct.

Source files
------------

// File: rtl/fp_div_scheduler_if.sv
//------------------------------------------------------------------------------
// fp_div_scheduler_if : request, datapath and response signals of the divider scheduler
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface fp_div_scheduler_if #(
  parameter int XLEN = 32
);
  logic            req0_valid;
  logic            req0_ready;
  logic [XLEN-1:0] req0_a;
  logic [XLEN-1:0] req0_b;
  logic            req1_valid;
  logic            req1_ready;
  logic [XLEN-1:0] req1_a;
  logic [XLEN-1:0] req1_b;
  logic [XLEN-1:0] div_a;
  logic [XLEN-1:0] div_b;
  logic [XLEN-1:0] div_result;
  logic            div_overflow;
  logic            div_underflow;
  logic            div_exception;
  logic            rsp_valid;
  logic            rsp_ready;
  logic            rsp_id;
  logic [XLEN-1:0] rsp_result;
  logic            rsp_overflow;
  logic            rsp_underflow;
  logic            rsp_exception;
  logic            busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    input  div_result, div_overflow, div_underflow, div_exception, rsp_ready,
    output req0_ready, req1_ready, div_a, div_b,
    output rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_underflow, rsp_exception, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    output div_result, div_overflow, div_underflow, div_exception, rsp_ready,
    input  req0_ready, req1_ready, div_a, div_b,
    input  rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_underflow, rsp_exception, busy
  );
endinterface

`default_nettype wire

// File: rtl/fp_div_scheduler.sv
//------------------------------------------------------------------------------
// fp_div_scheduler : round-robin sharing of one fixed-latency FP divider, with
//                    IEEE special operands resolved locally
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fp_div_scheduler #(
  parameter int XLEN    = 32,
  parameter int LATENCY = 8
) (
  input  wire logic         clk,
  input  wire logic         rst,
  fp_div_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0]      c_CNT_INIT = 8'(LATENCY - 1);
  localparam logic [XLEN-1:0] c_QNAN     = 32'h7FC0_0000;

  state_t          r_state;
  logic            r_ptr;
  logic [7:0]      r_cnt;
  logic [XLEN-1:0] r_div_a;
  logic [XLEN-1:0] r_div_b;
  logic            r_rsp_id;
  logic [XLEN-1:0] r_rsp_result;
  logic            r_rsp_ovf;
  logic            r_rsp_unf;
  logic            r_rsp_exc;
  logic            r_rsp_valid;
  logic            r_busy;

  logic            w_idle;
  logic            w_gnt0;
  logic            w_gnt1;
  logic            w_accept;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic            w_a_zero, w_a_inf, w_a_nan;
  logic            w_b_zero, w_b_inf, w_b_nan;
  logic            w_sign;
  logic            w_special;
  logic            w_sp_exc;
  logic [XLEN-1:0] w_sp_result;

  // Ready is gated by rst so nothing is granted while reset is being applied.
  assign w_idle   = (r_state == S_IDLE) && !rst;
  assign w_gnt0   = w_idle && bus.req0_valid && (!bus.req1_valid || !r_ptr);
  assign w_gnt1   = w_idle && bus.req1_valid && (!bus.req0_valid || r_ptr);
  assign w_accept = w_gnt0 || w_gnt1;
  assign w_a      = w_gnt1 ? bus.req1_a : bus.req0_a;
  assign w_b      = w_gnt1 ? bus.req1_b : bus.req0_b;

  // Exponent zero covers denormals too: they are flushed to zero.
  assign w_a_zero = (w_a[30:23] == 8'h00);
  assign w_a_inf  = (w_a[30:23] == 8'hFF) && (w_a[22:0] == 23'h0);
  assign w_a_nan  = (w_a[30:23] == 8'hFF) && (w_a[22:0] != 23'h0);
  assign w_b_zero = (w_b[30:23] == 8'h00);
  assign w_b_inf  = (w_b[30:23] == 8'hFF) && (w_b[22:0] == 23'h0);
  assign w_b_nan  = (w_b[30:23] == 8'hFF) && (w_b[22:0] != 23'h0);
  assign w_sign   = w_a[31] ^ w_b[31];

  always_comb begin
    w_special   = 1'b1;
    w_sp_exc    = 1'b0;
    w_sp_result = '0;
    if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
      w_sp_result = c_QNAN;
      w_sp_exc    = 1'b1;
    end else if (w_a_inf) begin
      w_sp_result = {w_sign, 8'hFF, 23'h0};
    end else if (w_b_zero) begin
      w_sp_result = {w_sign, 8'hFF, 23'h0};
      w_sp_exc    = 1'b1;
    end else if (w_a_zero || w_b_inf) begin
      w_sp_result = {w_sign, 31'h0};
    end else begin
      w_special   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_ptr        <= 1'b0;
      r_cnt        <= '0;
      r_div_a      <= '0;
      r_div_b      <= '0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_ovf    <= 1'b0;
      r_rsp_unf    <= 1'b0;
      r_rsp_exc    <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_div_a  <= w_a;
            r_div_b  <= w_b;
            r_rsp_id <= w_gnt1;
            r_ptr    <= w_gnt0;
            r_busy   <= 1'b1;
            if (w_special) begin
              r_rsp_result <= w_sp_result;
              r_rsp_exc    <= w_sp_exc;
              r_rsp_ovf    <= 1'b0;
              r_rsp_unf    <= 1'b0;
              r_rsp_valid  <= 1'b1;
              r_state      <= S_DONE;
            end else begin
              r_cnt   <= c_CNT_INIT;
              r_state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (r_cnt == 8'd0) begin
            r_rsp_result <= bus.div_result;
            r_rsp_ovf    <= bus.div_overflow;
            r_rsp_unf    <= bus.div_underflow;
            r_rsp_exc    <= bus.div_exception;
            r_rsp_valid  <= 1'b1;
            r_state      <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_DONE: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req0_ready    = w_gnt0;
  assign bus.req1_ready    = w_gnt1;
  assign bus.div_a         = r_div_a;
  assign bus.div_b         = r_div_b;
  assign bus.rsp_valid     = r_rsp_valid;
  assign bus.rsp_id        = r_rsp_id;
  assign bus.rsp_result    = r_rsp_result;
  assign bus.rsp_overflow  = r_rsp_ovf;
  assign bus.rsp_underflow = r_rsp_unf;
  assign bus.rsp_exception = r_rsp_exc;
  assign bus.busy          = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_fp_div_scheduler.sv
//------------------------------------------------------------------------------
// tb_fp_div_scheduler : directed and random checks of the divider scheduler
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fp_div_scheduler;
  localparam int LAT = 8;

  typedef enum {C_ZERO, C_FIN, C_INF, C_NAN} cls_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   dp_cnt  = 0;
  int   dp1_cnt = 0;

  always #5 clk = ~clk;

  fp_div_scheduler_if #(.XLEN(32)) u_if ();
  fp_div_scheduler_if #(.XLEN(32)) u_if1 ();

  fp_div_scheduler #(.XLEN(32), .LATENCY(LAT)) u_dut  (.clk(clk), .rst(rst), .bus(u_if.slave));
  fp_div_scheduler #(.XLEN(32), .LATENCY(1))   u_dut1 (.clk(clk), .rst(rst), .bus(u_if1.slave));

  // Stand-in divider: a known quotient for 6.0/2.0, otherwise a scrambled value.
  function automatic logic [31:0] dp_fn(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40C0_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  // The divider output is only meaningful once operands have been stable LAT cycles.
  always @(negedge clk) begin
    if (rst || (u_if.req0_valid && u_if.req0_ready) || (u_if.req1_valid && u_if.req1_ready)) dp_cnt <= 0;
    else if (dp_cnt < 1000) dp_cnt <= dp_cnt + 1;
    if (rst || (u_if1.req0_valid && u_if1.req0_ready) || (u_if1.req1_valid && u_if1.req1_ready)) dp1_cnt <= 0;
    else if (dp1_cnt < 1000) dp1_cnt <= dp1_cnt + 1;
  end

  logic [31:0] w_q, w_q1;
  assign w_q  = (dp_cnt  >= LAT) ? dp_fn(u_if.div_a,  u_if.div_b)  : 32'hDEAD_BEEF;
  assign w_q1 = (dp1_cnt >= 1)   ? dp_fn(u_if1.div_a, u_if1.div_b) : 32'hDEAD_BEEF;
  assign u_if.div_result  = w_q;
  assign {u_if.div_exception, u_if.div_underflow, u_if.div_overflow}    = w_q[2:0];
  assign u_if1.div_result = w_q1;
  assign {u_if1.div_exception, u_if1.div_underflow, u_if1.div_overflow} = w_q1[2:0];

  function automatic cls_t classify(input logic [31:0] x);
    if (x[30:23] == 8'h00) return C_ZERO;
    if (x[30:23] != 8'hFF) return C_FIN;
    if (x[22:0] != 23'h0)  return C_NAN;
    return C_INF;
  endfunction

  task automatic model(input logic [31:0] a, input logic [31:0] b, output logic [31:0] r,
                       output logic exc, output logic ovf, output logic unf, output bit sp);
    cls_t ca = classify(a);
    cls_t cb = classify(b);
    logic s  = a[31] ^ b[31];
    logic [31:0] q;
    sp = 1'b1; ovf = 1'b0; unf = 1'b0; exc = 1'b0;
    if (ca == C_NAN || cb == C_NAN || (ca == cb && ca != C_FIN)) begin
      r = 32'h7FC0_0000; exc = 1'b1;
    end else if (ca == C_INF) begin
      r = {s, 8'hFF, 23'h0};
    end else if (cb == C_ZERO) begin
      r = {s, 8'hFF, 23'h0}; exc = 1'b1;
    end else if (ca == C_ZERO || cb == C_INF) begin
      r = {s, 31'h0};
    end else begin
      sp = 1'b0;
      q  = dp_fn(a, b);
      r  = q;
      {exc, unf, ovf} = q[2:0];
    end
  endtask

  function automatic logic [31:0] gen_operand();
    logic        s = 1'($urandom_range(0, 1));
    logic [22:0] m = 23'($urandom());
    case ($urandom_range(0, 6))
      0:       return {s, 8'h00, m};
      1:       return {s, 8'hFF, 23'h0};
      2:       return {s, 8'hFF, m | 23'h1};
      default: return {s, 8'($urandom_range(1, 254)), m};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic finish_op(input bit id, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] er, snap_r;
    logic        eexc, eovf, eunf;
    logic [3:0]  snap_m;
    bit          sp;
    int          lat = 1;
    int          bad = 0;
    model(a, b, er, eexc, eovf, eunf, sp);
    while (!u_if.rsp_valid && lat < 400) begin
      step();
      lat++;
    end
    chk($sformatf("latency %h/%h", a, b), lat, sp ? 1 : LAT + 1);
    chk("rsp_id", u_if.rsp_id, id);
    chk($sformatf("rsp_result %h/%h", a, b), u_if.rsp_result, er);
    chk("rsp_flags", {u_if.rsp_exception, u_if.rsp_underflow, u_if.rsp_overflow}, {eexc, eunf, eovf});
    chk("busy_in_done", u_if.busy, 1'b1);
    if (hold > 0) begin
      snap_r = u_if.rsp_result;
      snap_m = {u_if.rsp_id, u_if.rsp_exception, u_if.rsp_underflow, u_if.rsp_overflow};
      u_if.req0_valid = 1'b1;
      u_if.req1_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        step();
        if (u_if.rsp_result !== snap_r || u_if.rsp_valid !== 1'b1 || u_if.busy !== 1'b1 ||
            {u_if.rsp_id, u_if.rsp_exception, u_if.rsp_underflow, u_if.rsp_overflow} !== snap_m ||
            u_if.req0_ready !== 1'b0 || u_if.req1_ready !== 1'b0) bad++;
      end
      chk("backpressure_stable", bad, 0);
    end
    u_if.rsp_ready = 1'b1;
    step();
    u_if.rsp_ready = 1'b0;
    chk("back_to_idle", {u_if.rsp_valid, u_if.busy}, 2'b00);
    if (hold > 0) begin
      chk("grant_after_done", {u_if.req0_ready, u_if.req1_ready}, id ? 2'b10 : 2'b01);
      u_if.req0_valid = 1'b0;
      u_if.req1_valid = 1'b0;
    end
  endtask

  task automatic run_op(input bit id, input logic [31:0] a, input logic [31:0] b, input int hold);
    bit got = 1'b0;
    if (id) begin u_if.req1_valid = 1'b1; u_if.req1_a = a; u_if.req1_b = b; end
    else    begin u_if.req0_valid = 1'b1; u_if.req0_a = a; u_if.req0_b = b; end
    for (int i = 0; i < 50 && !got; i++) begin
      #1;
      got = id ? u_if.req1_ready : u_if.req0_ready;
      step();
    end
    u_if.req0_valid = 1'b0;
    u_if.req1_valid = 1'b0;
    chk("accept", got, 1'b1);
    finish_op(id, a, b, hold);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
  endtask

  initial begin
    int          ngr, both, lat, exp_id;
    int          grants[$];
    int          pend[$];
    logic [31:0] la[2], lb[2];

    {u_if.req0_valid, u_if.req1_valid, u_if.rsp_ready}    = '0;
    {u_if.req0_a, u_if.req0_b, u_if.req1_a, u_if.req1_b}  = '0;
    {u_if1.req0_valid, u_if1.req1_valid, u_if1.rsp_ready} = '0;
    {u_if1.req0_a, u_if1.req0_b, u_if1.req1_a, u_if1.req1_b} = '0;

    repeat (3) step();
    chk("reset_ctrl", {u_if.busy, u_if.rsp_valid, u_if.rsp_id, u_if.rsp_exception, u_if.rsp_underflow,
                       u_if.rsp_overflow, u_if.req0_ready, u_if.req1_ready}, 8'h00);
    chk("reset_div_a", u_if.div_a, 32'h0);
    chk("reset_result", u_if.rsp_result, 32'h0);
    rst = 1'b0;

    run_op(1'b0, 32'h40C0_0000, 32'h4000_0000, 0);
    run_op(1'b0, 32'h3F80_0000, 32'h0000_0000, 0);
    run_op(1'b1, 32'h8000_0000, 32'h3F80_0000, 0);
    run_op(1'b0, 32'h7FC0_0001, 32'h3F80_0000, 0);
    run_op(1'b0, 32'h4120_0000, 32'h3FC0_0000, 20);

    // Both requesters held valid from reset: grants must alternate starting at 0.
    do_reset();
    u_if.req0_a = 32'h40C0_0000; u_if.req0_b = 32'h4000_0000;
    u_if.req1_a = 32'h3F80_0000; u_if.req1_b = 32'h4040_0000;
    u_if.req0_valid = 1'b1; u_if.req1_valid = 1'b1; u_if.rsp_ready = 1'b1;
    ngr = 0; both = 0;
    for (int c = 0; c < 200 && ngr < 4; c++) begin
      #1;
      if (u_if.rsp_valid) begin
        exp_id = (pend.size() > 0) ? pend.pop_front() : 2;
        chk("arb_rsp_id", u_if.rsp_id, exp_id);
      end
      if (u_if.req0_ready && u_if.req1_ready) both++;
      if (u_if.req0_ready) begin grants.push_back(0); pend.push_back(0); ngr++; end
      if (u_if.req1_ready) begin grants.push_back(1); pend.push_back(1); ngr++; end
      step();
    end
    u_if.req0_valid = 1'b0; u_if.req1_valid = 1'b0;
    for (int c = 0; c < 100 && !u_if.rsp_valid; c++) step();
    chk("arb_drain_valid", u_if.rsp_valid, 1'b1);
    exp_id = (pend.size() > 0) ? pend.pop_front() : 2;
    chk("arb_drain_id", u_if.rsp_id, exp_id);
    step();
    u_if.rsp_ready = 1'b0;
    chk("arb_both_ready", both, 0);
    chk("arb_grants", ngr, 4);
    foreach (grants[i]) chk($sformatf("arb_order[%0d]", i), grants[i], i % 2);

    for (int i = 0; i < 40; i++) run_op(1'($urandom_range(0, 1)), gen_operand(), gen_operand(), 0);

    // Reset while BUSY with the down-counter at 3, then accept straight after.
    u_if.req0_valid = 1'b1; u_if.req0_a = 32'h4100_0000; u_if.req0_b = 32'h4080_0000;
    #1;
    chk("mid_accept", u_if.req0_ready, 1'b1);
    step();
    u_if.req0_valid = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    chk("mid_rst_ctrl", {u_if.busy, u_if.rsp_valid, u_if.rsp_id, u_if.rsp_exception, u_if.rsp_underflow,
                         u_if.rsp_overflow, u_if.req0_ready, u_if.req1_ready}, 8'h00);
    chk("mid_rst_div", u_if.div_a | u_if.div_b, 32'h0);
    chk("mid_rst_result", u_if.rsp_result, 32'h0);
    u_if.req0_valid = 1'b1; u_if.req0_a = 32'h40C0_0000; u_if.req0_b = 32'h4000_0000;
    rst = 1'b0;
    #1;
    chk("post_rst_accept", u_if.req0_ready, 1'b1);
    step();
    u_if.req0_valid = 1'b0;
    finish_op(1'b0, 32'h40C0_0000, 32'h4000_0000, 0);

    // LATENCY=1 instance: capture must happen on the very first BUSY cycle.
    la[0] = 32'h40C0_0000; lb[0] = 32'h4000_0000;
    la[1] = 32'h3FC0_0000; lb[1] = 32'h40A0_0000;
    for (int k = 0; k < 2; k++) begin
      u_if1.req0_valid = 1'b1; u_if1.req0_a = la[k]; u_if1.req0_b = lb[k];
      #1;
      chk("l1_accept", u_if1.req0_ready, 1'b1);
      step();
      u_if1.req0_valid = 1'b0;
      lat = 1;
      while (!u_if1.rsp_valid && lat < 50) begin
        step();
        lat++;
      end
      chk("l1_latency", lat, 2);
      chk("l1_result", u_if1.rsp_result, dp_fn(la[k], lb[k]));
      chk("l1_flags", {u_if1.rsp_exception, u_if1.rsp_underflow, u_if1.rsp_overflow},
          {29'h0, dp_fn(la[k], lb[k]) & 32'h7});
      u_if1.rsp_ready = 1'b1;
      step();
      u_if1.rsp_ready = 1'b0;
      chk("l1_idle", {u_if1.rsp_valid, u_if1.busy}, 2'b00);
    end
    chk("l1_known_quotient", u_if1.rsp_result, dp_fn(la[1], lb[1]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
